// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32I-subset core: each instruction walks IF, ID, EX, MEM, WB.
// Instruction ROM and data RAM are external and synchronous.
module riscv_multicycle_core #(
  parameter logic [31:0] INITIAL_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] dReadData,
  output logic [31:0] PC,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] WriteBackData
);

  typedef enum logic [2:0] {
    IF_S  = 3'd0,
    ID_S  = 3'd1,
    EX_S  = 3'd2,
    MEM_S = 3'd3,
    WB_S  = 3'd4
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  state_t      stateReg, stateNext;
  logic [31:0] regFile [32];
  logic [31:0] aluOut, aluResult, aluA, aluB, imm, rs1Val, rs2Val;
  logic [3:0]  aluCtrl;
  logic        memToReg, branchTaken;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic       isR, isI, isLoad, isStore, isBranch, regWrite;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign isR      = (opcode == OP_R);
  assign isI      = (opcode == OP_I);
  assign isLoad   = (opcode == OP_LOAD);
  assign isStore  = (opcode == OP_STORE);
  assign isBranch = (opcode == OP_BEQ);
  assign regWrite = isR | isI | isLoad;

  assign rs1Val = (rs1 == 5'd0) ? 32'd0 : regFile[rs1];
  assign rs2Val = (rs2 == 5'd0) ? 32'd0 : regFile[rs2];

  // Immediate generator
  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (opcode)
      OP_STORE: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BEQ:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:  imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // ALU control: loads/stores add, BEQ subtracts; instr[30] selects SUB/SRA
  always_comb begin
    aluCtrl = ALU_ADD;
    if (isR || isI) begin
      case (funct3)
        3'b000:  aluCtrl = (isR && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b111:  aluCtrl = ALU_AND;
        3'b110:  aluCtrl = ALU_OR;
        3'b100:  aluCtrl = ALU_XOR;
        3'b010:  aluCtrl = ALU_SLT;
        3'b001:  aluCtrl = ALU_SLL;
        3'b101:  aluCtrl = instr[30] ? ALU_SRA : ALU_SRL;
        default: aluCtrl = ALU_ADD;
      endcase
    end else if (isBranch) begin
      aluCtrl = ALU_SUB;
    end else begin
      aluCtrl = ALU_ADD;
    end
  end

  assign aluA = rs1Val;
  assign aluB = (isR || isBranch) ? rs2Val : imm;

  // ALU datapath
  always_comb begin
    aluResult = 32'd0;
    case (aluCtrl)
      ALU_ADD: aluResult = aluA + aluB;
      ALU_SUB: aluResult = aluA - aluB;
      ALU_AND: aluResult = aluA & aluB;
      ALU_OR:  aluResult = aluA | aluB;
      ALU_XOR: aluResult = aluA ^ aluB;
      ALU_SLT: aluResult = {31'd0, ($signed(aluA) < $signed(aluB))};
      ALU_SLL: aluResult = aluA << aluB[4:0];
      ALU_SRL: aluResult = aluA >> aluB[4:0];
      ALU_SRA: aluResult = $unsigned($signed(aluA) >>> aluB[4:0]);
      default: aluResult = aluA + aluB;
    endcase
  end

  // The registered ALU result doubles as the zero flag source for BEQ in WB
  assign branchTaken = isBranch && (aluOut == 32'd0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) stateReg <= IF_S;
    else     stateReg <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = IF_S;
    case (stateReg)
      IF_S:    stateNext = ID_S;
      ID_S:    stateNext = EX_S;
      EX_S:    stateNext = MEM_S;
      MEM_S:   stateNext = WB_S;
      WB_S:    stateNext = IF_S;
      default: stateNext = IF_S;
    endcase
  end

  // FSM control outputs
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    memToReg = 1'b0;
    case (stateReg)
      MEM_S: begin
        MemRead  = isLoad;
        MemWrite = isStore;
      end
      WB_S:    memToReg = isLoad;
      default: memToReg = 1'b0;
    endcase
  end

  // ALU result register, captured at the end of EX
  always_ff @(posedge clk) begin
    if (rst)                   aluOut <= 32'd0;
    else if (stateReg == EX_S) aluOut <= aluResult;
  end

  // Program counter, updated at the end of WB
  always_ff @(posedge clk) begin
    if (rst)                   PC <= INITIAL_PC;
    else if (stateReg == WB_S) PC <= branchTaken ? (PC + imm) : (PC + 32'd4);
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
    end else if ((stateReg == WB_S) && regWrite && (rd != 5'd0)) begin
      regFile[rd] <= WriteBackData;
    end
  end

  assign dAddress      = aluOut;
  assign dWriteData    = rs2Val;
  assign WriteBackData = memToReg ? dReadData : aluOut;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Scoreboard bench for riscv_multicycle_core: directed program, expected
// per-instruction results queued up front, checked by a phase-tracking monitor.
module tb_riscv_multicycle_core;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr, dReadData;
  logic [31:0] PC, dAddress, dWriteData, WriteBackData;
  logic        MemRead, MemWrite;

  riscv_multicycle_core #(.INITIAL_PC(BASE)) dut (
    .clk(clk), .rst(rst), .instr(instr), .dReadData(dReadData),
    .PC(PC), .dAddress(dAddress), .dWriteData(dWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .WriteBackData(WriteBackData)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [64];
  logic [31:0] ram [64];

  // Synchronous ROM and RAM models
  always @(posedge clk) begin
    instr <= rom[PC[7:2]];
    if (MemWrite === 1'b1) ram[dAddress[7:2]] <= dWriteData;
    dReadData <= ram[dAddress[7:2]];
  end

  typedef struct {
    int          id;
    bit          wbChk;
    logic [31:0] wb;
    bit          memRd;
    bit          memWr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] nextPc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (instr %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic push(input int id, input bit wbChk, input logic [31:0] wb, input bit rd,
                      input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] nextOff);
    exp_t e;
    e.id = id; e.wbChk = wbChk; e.wb = wb; e.memRd = rd; e.memWr = wr;
    e.addr = addr; e.wdata = wdata; e.nextPc = BASE + nextOff;
    q.push_back(e);
  endtask

  // Phase tracker: reset puts the core in IF, then one state per edge
  int phase = 0;
  bit lastRst = 1'b0;
  bit active = 1'b0;
  always @(posedge clk) begin
    lastRst <= rst;
    if (rst) begin
      phase  <= 0;
      active <= 1'b1;
    end else if (active) begin
      phase <= (phase == 4) ? 0 : phase + 1;
    end
  end

  // Monitor: compares DUT outputs against the queued expectations
  bit          pendPc = 1'b0;
  logic [31:0] pendNext;
  exp_t        cur;
  always @(negedge clk) begin
    if (active) begin
      if (lastRst) begin
        check("reset PC", -1, PC, BASE);
        check("reset MemRead", -1, {31'd0, MemRead}, 32'd0);
        check("reset MemWrite", -1, {31'd0, MemWrite}, 32'd0);
        check("reset WriteBackData", -1, WriteBackData, 32'd0);
        pendPc = 1'b0;
      end else begin
        if (phase == 0 && pendPc) begin
          check("next PC", cur.id, PC, pendNext);
          pendPc = 1'b0;
        end
        if (phase == 3) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard underflow at MEM: got empty queue, required an entry");
          end else begin
            cur = q[0];
            check("MemRead", cur.id, {31'd0, MemRead}, {31'd0, cur.memRd});
            check("MemWrite", cur.id, {31'd0, MemWrite}, {31'd0, cur.memWr});
            if (cur.memRd || cur.memWr) check("dAddress", cur.id, dAddress, cur.addr);
            if (cur.memWr) check("dWriteData", cur.id, dWriteData, cur.wdata);
          end
        end else begin
          check("idle MemRead", -1, {31'd0, MemRead}, 32'd0);
          check("idle MemWrite", -1, {31'd0, MemWrite}, 32'd0);
        end
        if (phase == 4) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard underflow at WB: got empty queue, required an entry");
          end else begin
            cur = q.pop_front();
            if (cur.wbChk) check("WriteBackData", cur.id, WriteBackData, cur.wb);
            pendNext = cur.nextPc;
            pendPc   = 1'b1;
          end
        end
      end
    end
  end

  task automatic waitDrain(input string what);
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout %s: got %0d entries pending, required 0", what, q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = 32'h0000_0013;
      ram[i] = 32'd0;
    end
    rom[0]  = 32'h0050_0093; // ADDI x1,x0,5
    rom[1]  = 32'hFFD0_0113; // ADDI x2,x0,-3
    rom[2]  = 32'h0020_81B3; // ADD  x3,x1,x2
    rom[3]  = 32'h4020_8233; // SUB  x4,x1,x2
    rom[4]  = 32'h0010_8663; // BEQ  x1,x1,+12
    rom[5]  = 32'h0010_0F93; // ADDI x31,x0,1 (skipped)
    rom[6]  = 32'h0010_0F93; // ADDI x31,x0,1 (skipped)
    rom[7]  = 32'h0011_22B3; // SLT  x5,x2,x1
    rom[8]  = 32'h4011_5313; // SRAI x6,x2,1
    rom[9]  = 32'h01C1_5393; // SRLI x7,x2,28
    rom[10] = 32'h0030_2423; // SW   x3,8(x0)
    rom[11] = 32'h0080_2403; // LW   x8,8(x0)
    rom[12] = 32'h0070_0013; // ADDI x0,x0,7
    rom[13] = 32'h0000_04B3; // ADD  x9,x0,x0
    rom[14] = 32'h0004_0533; // ADD  x10,x8,x0
    rom[15] = 32'h0006_06B3; // ADD  x13,x12,x0
    rom[16] = 32'h0020_8663; // BEQ  x1,x2,+12
    rom[17] = 32'h0006_0733; // ADD  x14,x12,x0
    rom[18] = 32'h0050_0FFF; // unsupported opcode
    rom[19] = 32'h000F_87B3; // ADD  x15,x31,x0
    rom[20] = 32'h0030_2623; // SW   x3,12(x0) (aborted by reset)

    //   id  wbChk wb            rd wr addr   wdata  nextOff
    push(0,  1, 32'h0000_0005, 0, 0, 32'd0, 32'd0, 32'h04);
    push(1,  1, 32'hFFFF_FFFD, 0, 0, 32'd0, 32'd0, 32'h08);
    push(2,  1, 32'h0000_0002, 0, 0, 32'd0, 32'd0, 32'h0C);
    push(3,  1, 32'h0000_0008, 0, 0, 32'd0, 32'd0, 32'h10);
    push(4,  1, 32'h0000_0000, 0, 0, 32'd0, 32'd0, 32'h1C);
    push(7,  1, 32'h0000_0001, 0, 0, 32'd0, 32'd0, 32'h20);
    push(8,  1, 32'hFFFF_FFFE, 0, 0, 32'd0, 32'd0, 32'h24);
    push(9,  1, 32'h0000_000F, 0, 0, 32'd0, 32'd0, 32'h28);
    push(10, 1, 32'h0000_0008, 0, 1, 32'd8, 32'd2, 32'h2C);
    push(11, 1, 32'h0000_0002, 1, 0, 32'd8, 32'd0, 32'h30);
    push(12, 1, 32'h0000_0007, 0, 0, 32'd0, 32'd0, 32'h34);
    push(13, 1, 32'h0000_0000, 0, 0, 32'd0, 32'd0, 32'h38);
    push(14, 1, 32'h0000_0002, 0, 0, 32'd0, 32'd0, 32'h3C);
    push(15, 1, 32'h0000_0000, 0, 0, 32'd0, 32'd0, 32'h40);
    push(16, 1, 32'h0000_0008, 0, 0, 32'd0, 32'd0, 32'h44);
    push(17, 1, 32'h0000_0000, 0, 0, 32'd0, 32'd0, 32'h48);
    push(18, 0, 32'h0000_0000, 0, 0, 32'd0, 32'd0, 32'h4C);
    push(19, 1, 32'h0000_0000, 0, 0, 32'd0, 32'd0, 32'h50);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    waitDrain("run 1");

    // Assert reset in the EX cycle of the SW at offset 0x50
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge clk);
        if (phase == 2 && PC == BASE + 32'h50) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL timeout sw-abort sync: got no EX cycle at PC %h, required one", BASE + 32'h50);
      end
    end
    rst = 1'b1;
    rom[4] = 32'h0020_8663; // BEQ x1,x2,+12 (not taken)
    push(0,  1, 32'h0000_0005, 0, 0, 32'd0, 32'd0, 32'h04);
    push(1,  1, 32'hFFFF_FFFD, 0, 0, 32'd0, 32'd0, 32'h08);
    push(2,  1, 32'h0000_0002, 0, 0, 32'd0, 32'd0, 32'h0C);
    push(3,  1, 32'h0000_0008, 0, 0, 32'd0, 32'd0, 32'h10);
    push(4,  1, 32'h0000_0008, 0, 0, 32'd0, 32'd0, 32'h14);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    waitDrain("run 2");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
- Multicycle RV32I-subset processor core. Every instruction steps through a fixed 5-state FSM: IF, ID, EX, MEM, WB.
- Connects to an external synchronous instruction ROM (fed by PC, returns instr) and an external data RAM (dAddress, dWriteData, MemWrite, returns dReadData).
- Contains the PC, a 32x32 register file, the ALU, the immediate generator, the control decoder and the FSM.

Parameters:
INITIAL_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
instr  input  32  instruction word from the instruction ROM for the current PC.
dReadData  input  32  data word from the data RAM.
PC  output  32  current program counter; drives the instruction ROM address.
dAddress  output  32  data RAM byte address (ALU result).
dWriteData  output  32  store data (rs2 register value).
MemRead  output  1  high only in MEM state for LW.
MemWrite  output  1  high only in MEM state for SW.
WriteBackData  output  32  value written to rd: dReadData for LW, otherwise the registered ALU result.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - PC=INITIAL_PC, FSM=IF, all 32 registers=0, ALU result register=0.
  - Therefore MemRead=0, MemWrite=0, WriteBackData=0.
  - Reset mid-instruction aborts that instruction; no register or memory write occurs.
- FSM: IF->ID->EX->MEM->WB->IF, one state per cycle, 5 cycles per instruction regardless of type.
  - PC is held constant from IF through WB.
  - The synchronous ROM presents instr from ID onward; instr is treated as valid in ID, EX, MEM and WB.
- ID: decode opcode/funct3/funct7, read rs1/rs2, form the immediate:
  - I-type: instr[31:20], sign-extended.
  - S-type: {instr[31:25],instr[11:7]}, sign-extended.
  - B-type: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, sign-extended.
- EX: ALU computes its result; the result is registered at the end of EX. Zero flag = (result==0).
- Supported instructions:
  - R-type (0110011): ADD, SUB, AND, OR, XOR, SLT (signed), SLL, SRL, SRA.
  - I-type (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LW (0000011), SW (0100011), BEQ (1100011).
- ALU arithmetic:
  - 32-bit wrap-around add/sub; overflow ignored.
  - Shift amount = operand B[4:0].
  - SRA/SRAI sign-fill; SLT returns 1 or 0.
- LW/SW address = rs1 + imm. BEQ compares rs1 - rs2 and uses the zero flag.
- MEM:
  - dAddress = registered ALU result; dWriteData = rs2.
  - MemRead is asserted for LW, MemWrite for SW, for exactly this one cycle.
  - RAM write occurs on the clk edge ending MEM.
- WB:
  - dReadData is sampled in WB, one cycle after the MEM address.
  - Register write for R-type, I-type and LW on the edge ending WB; writes to x0 are discarded and x0 always reads 0.
  - PC update on the edge ending WB: PC+imm if BEQ and zero, else PC+4.
- WriteBackData is valid during WB. It is driven combinationally in every state from the mux (MemToReg ? dReadData : ALU result register).
- Unsupported opcodes execute as a NOP: no register or memory write, PC+4.
- Branch target arithmetic wraps modulo 2^32. No alignment checking is performed.

Test Plan:
- Reset: hold rst=1 for 2 edges -> PC=32'h0040_0000, MemRead=0, MemWrite=0, WriteBackData=0; after release, PC advances by 4 every 5 cycles.
- ADDI x1,x0,5 then ADDI x2,x0,-3 then ADD x3,x1,x2 -> WriteBackData in each WB = 5, 32'hFFFF_FFFD, 2.
- SUB/SLT/SRA with x1=5, x2=-3:
  - SUB x4,x1,x2 -> 8.
  - SLT x5,x2,x1 -> 1.
  - SRAI x6,x2,1 -> 32'hFFFF_FFFE.
  - SRLI x7,x2,28 -> 32'h0000_000F.
- SW x3,8(x0) then LW x8,8(x0):
  - SW MEM cycle: MemWrite=1, dAddress=8, dWriteData=2.
  - LW MEM cycle: MemRead=1.
  - LW WB: WriteBackData=2, x8=2.
- BEQ:
  - BEQ x1,x1,+12 at PC=0x0040_0010 -> next PC=0x0040_001C.
  - BEQ x1,x2,+12 -> next PC=0x0040_0014.
  - Neither case writes a register.
- ADDI x0,x0,7 then ADD x9,x0,x0 -> WriteBackData=0; x0 remains 0. Assert rst during EX of an SW -> MemWrite never asserted and PC returns to INITIAL_PC.
